// File: rtl/subleq_mem_if.sv
// Bus bundle between a SUBLEQ CPU/program loader and the shared 256x8 memory.
// The slave modport is the memory side; the master modport drives it.
interface subleq_mem_if;
  logic [7:0] i_raddr;
  logic [7:0] o_rdata;
  logic [7:0] i_waddr;
  logic [7:0] i_wdata;
  logic       i_we;
  logic       i_ld_start;
  logic       i_run;
  logic       i_ld_valid;
  logic [7:0] i_ld_data;
  logic       i_ld_last;
  logic       o_ld_ready;
  logic [8:0] o_ld_count;
  logic       o_cpu_rstn;

  modport slave (
    input  i_raddr, i_waddr, i_wdata, i_we, i_ld_start, i_run,
           i_ld_valid, i_ld_data, i_ld_last,
    output o_rdata, o_ld_ready, o_ld_count, o_cpu_rstn
  );

  modport master (
    output i_raddr, i_waddr, i_wdata, i_we, i_ld_start, i_run,
           i_ld_valid, i_ld_data, i_ld_last,
    input  o_rdata, o_ld_ready, o_ld_count, o_cpu_rstn
  );
endinterface

// File: rtl/subleq_mem.sv
// 256x8 program/data memory for a SUBLEQ core with a streaming program loader
// and a HALT/LOAD/RUN sequencer that holds the CPU in reset outside RUN.
//
// state | meaning
// HALT  | idle after reset; CPU held in reset, memory readable
// LOAD  | loader streams bytes into mem[ptr]; CPU held in reset
// RUN   | CPU released; CPU write port enabled
module subleq_mem (
  input  logic          i_clk,
  input  logic          i_rst,
  subleq_mem_if.slave   bus
);

  // One-hot so each status output is a plain flop bit.
  typedef enum logic [2:0] {
    ST_HALT = 3'b001,
    ST_LOAD = 3'b010,
    ST_RUN  = 3'b100
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] rdata_q;
  logic [7:0] mem_q [256];

  logic       ld_xfer;
  logic       cpu_wr;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  assign ld_xfer = (state_q == ST_LOAD) && bus.i_ld_valid;
  assign cpu_wr  = (state_q == ST_RUN) && bus.i_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_HALT;
      ptr_q   <= 8'h00;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HALT: begin
        if (bus.i_ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = 8'h00;
          cnt_d   = 9'd0;
        end else if (bus.i_run) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (ld_xfer) begin
          ptr_d = ptr_q + 8'd1;
          cnt_d = cnt_q + 9'd1;
          // A full 256-byte image ends the load even without a last marker.
          if (bus.i_ld_last || (ptr_q == 8'hFF)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = 8'h00;
          cnt_d   = 9'd0;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    bus.o_ld_ready = state_q[1];
    bus.o_cpu_rstn = state_q[2];
    bus.o_ld_count = cnt_q;
    bus.o_rdata    = rdata_q;
  end

  // Loader and CPU writes are mutually exclusive by state, so one port suffices.
  assign mem_we    = !i_rst && (ld_xfer || cpu_wr);
  assign mem_waddr = ld_xfer ? ptr_q : bus.i_waddr;
  assign mem_wdata = ld_xfer ? bus.i_ld_data : bus.i_wdata;

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_q <= 8'h00;
    else       rdata_q <= mem_q[bus.i_raddr];
  end

endmodule

// File: tb/tb_subleq_mem.sv
// Bench for subleq_mem: directed vector table, a full 256-byte load sequence,
// and randomized traffic compared each cycle against a behavioural model.
module tb_subleq_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subleq_mem_if bus ();

  subleq_mem dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst, st, rn, vl;
    logic [7:0] d;
    logic       lst, we;
    logic [7:0] wa, wd, ra;
    logic       er;
    logic [8:0] ec;
    logic       erstn;
    logic       crd;
    logic [7:0] erd;
  } vec_t;

  vec_t vecs[$];

  localparam int M_HALT = 0, M_LOAD = 1, M_RUN = 2;
  int         m_st  = M_HALT;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_rd;
  bit         m_rd_ok = 1'b0;

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_st = M_HALT; m_ptr = 0; m_cnt = 0; m_rd = 8'h00; m_rd_ok = 1'b1;
    end else begin
      m_rd    = m_mem[bus.i_raddr];
      m_rd_ok = m_known[bus.i_raddr];
      case (m_st)
        M_HALT: begin
          if (bus.i_ld_start) begin m_st = M_LOAD; m_ptr = 0; m_cnt = 0; end
          else if (bus.i_run) m_st = M_RUN;
        end
        M_LOAD: begin
          if (bus.i_ld_valid) begin
            m_mem[m_ptr]   = bus.i_ld_data;
            m_known[m_ptr] = 1'b1;
            m_cnt++;
            if (bus.i_ld_last || m_ptr == 255) m_st = M_RUN;
            m_ptr = (m_ptr + 1) % 256;
          end
        end
        default: begin
          if (bus.i_we) begin
            m_mem[bus.i_waddr]   = bus.i_wdata;
            m_known[bus.i_waddr] = 1'b1;
          end
          if (bus.i_ld_start) begin m_st = M_LOAD; m_ptr = 0; m_cnt = 0; end
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model ld_ready", {8'h0, bus.o_ld_ready}, {8'h0, (m_st == M_LOAD)});
    check("model cpu_rstn", {8'h0, bus.o_cpu_rstn}, {8'h0, (m_st == M_RUN)});
    check("model ld_count", bus.o_ld_count, 9'(m_cnt));
    if (m_rd_ok) check("model rdata", {1'b0, bus.o_rdata}, {1'b0, m_rd});
  endtask

  task automatic drive(vec_t v);
    rst            = v.rst;
    bus.i_ld_start = v.st;
    bus.i_run      = v.rn;
    bus.i_ld_valid = v.vl;
    bus.i_ld_data  = v.d;
    bus.i_ld_last  = v.lst;
    bus.i_we       = v.we;
    bus.i_waddr    = v.wa;
    bus.i_wdata    = v.wd;
    bus.i_raddr    = v.ra;
  endtask

  function automatic vec_t mk(bit r, bit st, bit rn, bit vl, logic [7:0] d, bit lst,
                              bit we, logic [7:0] wa, logic [7:0] wd, logic [7:0] ra,
                              bit er, logic [8:0] ec, bit erstn, bit crd, logic [7:0] erd);
    vec_t v;
    v.rst = r; v.st = st; v.rn = rn; v.vl = vl; v.d = d; v.lst = lst; v.we = we;
    v.wa = wa; v.wd = wd; v.ra = ra; v.er = er; v.ec = ec; v.erstn = erstn;
    v.crd = crd; v.erd = erd;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    z = mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00,0,9'd0,0,0,8'h00);
    drive(z);

    //        rst st rn vl data lst we wa    wd    ra   | rdy cnt rstn crd rdata
    vecs.push_back(mk(1,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00, 0,9'd0,0,1,8'h00));
    vecs.push_back(mk(1,0,0,1,8'h55,1,1,8'h00,8'h00,8'h00, 0,9'd0,0,1,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,0,1,8'h30,8'h99,8'h00, 1,9'd0,0,0,8'h00));
    vecs.push_back(mk(0,0,0,1,8'h03,0,0,8'h00,8'h00,8'h00, 1,9'd1,0,0,8'h00));
    vecs.push_back(mk(0,0,0,1,8'h04,0,0,8'h00,8'h00,8'h00, 1,9'd2,0,0,8'h00));
    vecs.push_back(mk(0,0,0,1,8'h00,1,0,8'h00,8'h00,8'h00, 0,9'd3,1,0,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h01, 0,9'd3,1,1,8'h04));
    vecs.push_back(mk(0,0,0,0,8'h00,0,1,8'h10,8'h11,8'h00, 0,9'd3,1,1,8'h03));
    vecs.push_back(mk(0,0,0,0,8'h00,0,1,8'h10,8'hAA,8'h10, 0,9'd3,1,1,8'h11));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h10, 0,9'd3,1,1,8'hAA));
    vecs.push_back(mk(0,0,1,1,8'hFF,0,0,8'h00,8'h00,8'h02, 0,9'd3,1,1,8'h00));
    vecs.push_back(mk(0,1,0,0,8'h00,0,1,8'h20,8'h77,8'h00, 1,9'd0,0,1,8'h03));
    vecs.push_back(mk(0,0,0,1,8'h5A,0,1,8'h00,8'hEE,8'h00, 1,9'd1,0,1,8'h03));
    vecs.push_back(mk(0,0,0,0,8'h99,0,1,8'h00,8'hEE,8'h00, 1,9'd1,0,1,8'h5A));
    vecs.push_back(mk(0,0,0,1,8'h6B,0,1,8'h00,8'hEE,8'h01, 1,9'd2,0,1,8'h04));
    vecs.push_back(mk(1,0,0,1,8'hC3,0,0,8'h00,8'h00,8'h01, 0,9'd0,0,1,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00, 0,9'd0,0,1,8'h5A));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h01, 0,9'd0,0,1,8'h6B));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h02, 0,9'd0,0,1,8'h00));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0,8'h00,8'h00,8'h20, 1,9'd0,0,1,8'h77));
    vecs.push_back(mk(0,0,0,1,8'h42,0,0,8'h00,8'h00,8'h10, 1,9'd1,0,1,8'hAA));
    vecs.push_back(mk(0,1,1,1,8'h43,1,0,8'h00,8'h00,8'h00, 0,9'd2,1,0,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00, 0,9'd2,1,1,8'h42));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0,8'h00,8'h00,8'h01, 1,9'd0,0,1,8'h43));
    vecs.push_back(mk(0,0,0,1,8'h44,0,0,8'h00,8'h00,8'h02, 1,9'd1,0,1,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00, 1,9'd1,0,1,8'h44));
    vecs.push_back(mk(1,0,0,0,8'h00,0,0,8'h00,8'h00,8'h00, 0,9'd0,0,1,8'h00));
    vecs.push_back(mk(0,0,1,0,8'h00,0,0,8'h00,8'h00,8'h00, 0,9'd0,1,0,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,1,8'h05,8'h66,8'h05, 0,9'd0,1,0,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00,0,0,8'h00,8'h00,8'h05, 0,9'd0,1,1,8'h66));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      cycle();
      check($sformatf("vec%0d ld_ready", i), {8'h0, bus.o_ld_ready}, {8'h0, vecs[i].er});
      check($sformatf("vec%0d ld_count", i), bus.o_ld_count, vecs[i].ec);
      check($sformatf("vec%0d cpu_rstn", i), {8'h0, bus.o_cpu_rstn}, {8'h0, vecs[i].erstn});
      if (vecs[i].crd)
        check($sformatf("vec%0d rdata", i), {1'b0, bus.o_rdata}, {1'b0, vecs[i].erd});
    end

    // Full-image load with no last marker: wraps to RUN after address 0xFF.
    drive(z); rst = 1'b1; cycle();
    drive(z); bus.i_ld_start = 1'b1; cycle();
    check("full ready at start", {8'h0, bus.o_ld_ready}, 9'd1);
    for (int i = 0; i < 256; i++) begin
      drive(z);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = 8'(i) ^ 8'h5C;
      cycle();
      if (i == 254) check("full ready before last", {8'h0, bus.o_ld_ready}, 9'd1);
    end
    check("full ready after", {8'h0, bus.o_ld_ready}, 9'd0);
    check("full cpu_rstn", {8'h0, bus.o_cpu_rstn}, 9'd1);
    check("full ld_count", bus.o_ld_count, 9'd256);
    drive(z); bus.i_raddr = 8'h00; cycle();
    check("full mem[00]", {1'b0, bus.o_rdata}, 9'h05C);
    drive(z); bus.i_raddr = 8'hFF; cycle();
    check("full mem[FF]", {1'b0, bus.o_rdata}, 9'h0A3);
    check("full count held", bus.o_ld_count, 9'd256);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(63) == 0);
      bus.i_ld_start = ($urandom_range(31) == 0);
      bus.i_run      = ($urandom_range(7) == 0);
      bus.i_ld_valid = $urandom_range(1);
      bus.i_ld_data  = 8'($urandom);
      bus.i_ld_last  = ($urandom_range(15) == 0);
      bus.i_we       = $urandom_range(1);
      bus.i_waddr    = 8'($urandom_range(15));
      bus.i_wdata    = 8'($urandom);
      bus.i_raddr    = ($urandom_range(1) == 1) ? bus.i_waddr : 8'($urandom_range(15));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
